// File: rtl/hw_demux_fifo.sv
// hw_demux_fifo: steers each input word to out0, out1, both or neither,
// with an independent DEPTH-entry FIFO and valid/ready handshake per output.
module hw_demux_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout0,
    output logic             dout0_valid,
    input  logic             dout0_ready,
    output logic [WIDTH-1:0] dout1,
    output logic             dout1_valid,
    input  logic             dout1_ready,
    output logic [CW-1:0]    drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]       full, vld, push, pop, rdy;
    logic [WIDTH-1:0] head [2];
    logic             acc;
    logic [CW-1:0]    drop_q, drop_d;

    // Full comes from registered counts only, so in_ready never sees dout*_ready.
    assign in_ready = (sel == 2'd3) ? 1'b1 :
                      (sel == 2'd2) ? !full[0] && !full[1] :
                      (sel == 2'd1) ? !full[1] : !full[0];
    assign acc     = in_valid && in_ready;
    assign push[0] = acc && (sel == 2'd0 || sel == 2'd2);
    assign push[1] = acc && (sel == 2'd1 || sel == 2'd2);
    assign rdy     = {dout1_ready, dout0_ready};
    assign pop     = vld & rdy;
    assign drop_d  = (acc && sel == 2'd3 && drop_q != '1) ? drop_q + CW'(1) : drop_q;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]    rd_q, wr_q;
        logic [AW:0]      cnt_q, cnt_d;
        assign cnt_d   = cnt_q + (AW+1)'(push[g]) - (AW+1)'(pop[g]);
        assign full[g] = cnt_q == (AW+1)'(DEPTH);
        assign vld[g]  = cnt_q != '0;
        assign head[g] = mem_q[rd_q];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                mem_q <= '{default: '0};
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push[g]) begin
                    mem_q[wr_q] <= din;
                    wr_q        <= wr_q + AW'(1);
                end
                if (pop[g]) rd_q <= rd_q + AW'(1);
                cnt_q <= cnt_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign dout0       = head[0];
    assign dout1       = head[1];
    assign dout0_valid = vld[0];
    assign dout1_valid = vld[1];
    assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_hw_demux_fifo.sv
// tb_hw_demux_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_hw_demux_fifo;
    localparam int D = 2;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [2:0] din = '0;
    logic [1:0] sel = '0;
    logic       in_valid = 1'b0, dout0_ready = 1'b0, dout1_ready = 1'b0;
    logic       in_ready, dout0_valid, dout1_valid;
    logic [2:0] dout0, dout1;
    logic [7:0] drop_cnt;

    int         total = 0, bad = 0;
    logic [2:0] q0[$], q1[$];
    int         mdrop = 0;
    bit         stall = 0;

    hw_demux_fifo #(.WIDTH(3), .DEPTH(D), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .dout0(dout0), .dout0_valid(dout0_valid),
        .dout0_ready(dout0_ready), .dout1(dout1), .dout1_valid(dout1_valid),
        .dout1_ready(dout1_ready), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ready(input logic [1:0] s);
        return (s == 2'd3) ? 1'b1 :
               (s == 2'd2) ? (q0.size() < D && q1.size() < D) :
               (s == 2'd1) ? (q1.size() < D) : (q0.size() < D);
    endfunction

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick;
        bit acc, p0, p1;
        logic [2:0] t;
        acc = in_valid && exp_ready(sel);
        p0  = dout0_ready && q0.size() > 0;
        p1  = dout1_ready && q1.size() > 0;
        @(posedge clk);
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            mdrop = 0;
            stall = 0;
        end else begin
            if (p0) t = q0.pop_front();
            if (p1) t = q1.pop_front();
            if (acc && (sel == 2'd0 || sel == 2'd2)) q0.push_back(din);
            if (acc && (sel == 2'd1 || sel == 2'd2)) q1.push_back(din);
            if (acc && sel == 2'd3 && mdrop < 255) mdrop++;
            stall = in_valid && !acc;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (3) tick();
        total++;
        if ({dout0_valid, dout1_valid, dout0, dout1, drop_cnt} !== 16'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {dout0_valid, dout1_valid, dout0, dout1, drop_cnt});
        end
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready);
            end
        end
    endtask

    task automatic test_route;
        dout0_ready = 1'b1;
        dout1_ready = 1'b1;
        in_valid = 1'b1; sel = 2'd0; din = 3'd2;
        tick();
        total++;
        if ({dout0_valid, dout0} !== {1'b1, 3'd2}) begin
            bad++;
            $display("FAIL route_out0 got=%b/%0d exp=1/2", dout0_valid, dout0);
        end
        sel = 2'd1; din = 3'd1;
        tick();
        total++;
        if ({dout1_valid, dout1, dout0_valid} !== {1'b1, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL route_out1 got=%b/%0d v0=%b exp=1/1 v0=0", dout1_valid, dout1, dout0_valid);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if ({dout0_valid, dout1_valid} !== 2'b00) begin
            bad++;
            $display("FAIL route_empty got=%b exp=00", {dout0_valid, dout1_valid});
        end
    endtask

    task automatic test_backpressure;
        dout0_ready = 1'b0;
        dout1_ready = 1'b1;
        in_valid = 1'b1; sel = 2'd0; din = 3'd3;
        tick();
        din = 3'd4;
        tick();
        din = 3'd5;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_full_ready got=%b exp=0", in_ready);
        end
        tick();
        total++;
        if ({dout0_valid, dout0} !== {1'b1, 3'd3}) begin
            bad++;
            $display("FAIL bp_head3 got=%b/%0d exp=1/3", dout0_valid, dout0);
        end
        dout0_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_bypass got=%b exp=0", in_ready);
        end
        tick();
        total++;
        if ({dout0_valid, dout0, in_ready} !== {1'b1, 3'd4, 1'b1}) begin
            bad++;
            $display("FAIL bp_head4 got=%b/%0d rdy=%b exp=1/4 rdy=1", dout0_valid, dout0, in_ready);
        end
        tick();
        total++;
        if ({dout0_valid, dout0} !== {1'b1, 3'd5}) begin
            bad++;
            $display("FAIL bp_head5 got=%b/%0d exp=1/5", dout0_valid, dout0);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (dout0_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain got=%b exp=0", dout0_valid);
        end
    endtask

    task automatic test_broadcast_block;
        dout0_ready = 1'b1;
        dout1_ready = 1'b0;
        in_valid = 1'b1; sel = 2'd1; din = 3'd7;
        tick();
        din = 3'd0;
        tick();
        sel = 2'd2; din = 3'd6;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bc_blocked_ready got=%b exp=0", in_ready);
        end
        tick();
        total++;
        if ({dout0_valid, dout1_valid, dout1} !== {1'b0, 1'b1, 3'd7}) begin
            bad++;
            $display("FAIL bc_not_written got=%b%b/%0d exp=01/7", dout0_valid, dout1_valid, dout1);
        end
        dout1_ready = 1'b1;
        tick();
        total++;
        if ({in_ready, dout0_valid} !== 2'b10) begin
            bad++;
            $display("FAIL bc_after_pop got=%b exp=10", {in_ready, dout0_valid});
        end
        dout1_ready = 1'b0;
        tick();
        total++;
        if ({dout0_valid, dout0} !== {1'b1, 3'd6}) begin
            bad++;
            $display("FAIL bc_out0 got=%b/%0d exp=1/6", dout0_valid, dout0);
        end
        in_valid = 1'b0;
        dout1_ready = 1'b1;
        tick();
        total++;
        if ({dout1_valid, dout1, dout0_valid} !== {1'b1, 3'd6, 1'b0}) begin
            bad++;
            $display("FAIL bc_out1 got=%b/%0d v0=%b exp=1/6 v0=0", dout1_valid, dout1, dout0_valid);
        end
        tick();
        total++;
        if (dout1_valid !== 1'b0) begin
            bad++;
            $display("FAIL bc_drain got=%b exp=0", dout1_valid);
        end
    endtask

    task automatic test_drop_saturate;
        dout0_ready = 1'b1;
        dout1_ready = 1'b1;
        in_valid = 1'b1; sel = 2'd3;
        for (int i = 0; i < 300; i++) begin
            din = 3'($urandom);
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL drop_ready i=%0d got=%b exp=1", i, in_ready);
            end
            tick();
            total++;
            if ({dout0_valid, dout1_valid, drop_cnt} !== {2'b00, 8'(mdrop)}) begin
                bad++;
                $display("FAIL drop_step i=%0d got=%b%b/%0d exp=00/%0d", i, dout0_valid, dout1_valid, drop_cnt, mdrop);
            end
        end
        total++;
        if (drop_cnt !== 8'd255) begin
            bad++;
            $display("FAIL drop_sat got=%0d exp=255", drop_cnt);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset;
        dout0_ready = 1'b0;
        dout1_ready = 1'b0;
        in_valid = 1'b1; sel = 2'd2; din = 3'd1;
        tick();
        din = 3'd2;
        tick();
        total++;
        if ({dout0_valid, dout1_valid, dout0, dout1} !== {2'b11, 3'd1, 3'd1}) begin
            bad++;
            $display("FAIL mr_filled got=%b%b/%0d/%0d exp=11/1/1", dout0_valid, dout1_valid, dout0, dout1);
        end
        rst_n = 1'b0;
        din = 3'd3;
        dout0_ready = 1'b1;
        dout1_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        total++;
        if ({dout0_valid, dout1_valid, dout0, dout1, drop_cnt} !== 16'd0) begin
            bad++;
            $display("FAIL mr_cleared got=%h exp=0", {dout0_valid, dout1_valid, dout0, dout1, drop_cnt});
        end
        in_valid = 1'b1; sel = 2'd0; din = 3'd5;
        tick();
        total++;
        if ({dout0_valid, dout0, dout1_valid} !== {1'b1, 3'd5, 1'b0}) begin
            bad++;
            $display("FAIL mr_new_traffic got=%b/%0d v1=%b exp=1/5 v1=0", dout0_valid, dout0, dout1_valid);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            if (!stall) begin
                in_valid = $urandom_range(0, 3) != 0;
                sel = 2'($urandom_range(0, 3));
                din = 3'($urandom);
            end
            dout0_ready = $urandom_range(0, 2) != 0;
            dout1_ready = $urandom_range(0, 2) != 0;
            #1;
            total++;
            if (in_ready !== exp_ready(sel)) begin
                bad++;
                $display("FAIL rnd_ready i=%0d sel=%0d got=%b exp=%b", i, sel, in_ready, exp_ready(sel));
            end
            tick();
            total++;
            if (dout0_valid !== (q0.size() > 0) || (q0.size() > 0 && dout0 !== q0[0])) begin
                bad++;
                $display("FAIL rnd_out0 i=%0d got=%b/%0d exp=%0d/%0d", i, dout0_valid, dout0, q0.size() > 0, q0.size() > 0 ? q0[0] : 3'd0);
            end
            total++;
            if (dout1_valid !== (q1.size() > 0) || (q1.size() > 0 && dout1 !== q1[0])) begin
                bad++;
                $display("FAIL rnd_out1 i=%0d got=%b/%0d exp=%0d/%0d", i, dout1_valid, dout1, q1.size() > 0, q1.size() > 0 ? q1[0] : 3'd0);
            end
            total++;
            if (drop_cnt !== 8'(mdrop)) begin
                bad++;
                $display("FAIL rnd_drop i=%0d got=%0d exp=%0d", i, drop_cnt, mdrop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_route();
        test_backpressure();
        test_broadcast_block();
        test_drop_saturate();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
